// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: shared state encoding, default parameters and counter sizing for the PLL reset sequencer
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RESET = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_seq_state_t;

    localparam int PLL_RST_CYCLES_DEF      = 16;
    localparam int LOCK_STABLE_CYCLES_DEF  = 1024;
    localparam int LOCK_TIMEOUT_CYCLES_DEF = 65536;
    localparam int MAX_RETRIES_DEF         = 7;
    localparam int SYNC_STAGES_DEF         = 2;

    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// sync_bit: multi-flop single-bit synchroniser with async active-low reset and selectable reset value
module sync_bit #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb sync_d = {sync_q[STAGES-2:0], d};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= {STAGES{RST_VAL}};
        else        sync_q <= sync_d;
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer: drives PLL reset, qualifies lock and issues a clean system reset with bounded retries
module pll_lock_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = PLL_RST_CYCLES_DEF,
    parameter int LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
    parameter int LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
    parameter int MAX_RETRIES         = MAX_RETRIES_DEF,
    parameter int SYNC_STAGES         = SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [3:0] retry_count,
    output logic       lock_lost
);
    localparam int RW = cnt_w(PLL_RST_CYCLES);
    localparam int SW = cnt_w(LOCK_STABLE_CYCLES);
    localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);

    pll_seq_state_t state_q, state_d;
    logic [RW-1:0]  rst_cnt_q, rst_cnt_d;
    logic [SW-1:0]  stb_cnt_q, stb_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic [3:0]     retry_q, retry_d;
    logic           lock_lost_d;
    logic           locked_s;

    sync_bit #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (locked),
        .q     (locked_s)
    );

    always_comb begin
        state_d     = state_q;
        rst_cnt_d   = rst_cnt_q;
        stb_cnt_d   = stb_cnt_q;
        to_cnt_d    = to_cnt_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;
        if (soft_reset_req) begin
            state_d   = PLL_RESET;
            rst_cnt_d = '0;
            stb_cnt_d = '0;
            to_cnt_d  = '0;
            retry_d   = '0;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    rst_cnt_d = (rst_cnt_q == RW'(PLL_RST_CYCLES - 1)) ? '0 : rst_cnt_q + RW'(1);
                    if (rst_cnt_q == RW'(PLL_RST_CYCLES - 1)) begin
                        state_d  = WAIT_LOCK;
                        to_cnt_d = '0;
                    end
                end
                WAIT_LOCK: begin
                    // lock seen in the timeout cycle still counts as a lock
                    if (locked_s) begin
                        state_d   = STABLE;
                        stb_cnt_d = '0;
                    end else if (to_cnt_q == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        state_d = (retry_q == 4'(MAX_RETRIES)) ? FAULT : PLL_RESET;
                        retry_d = (retry_q == 4'(MAX_RETRIES)) ? retry_q : retry_q + 4'd1;
                    end else begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                end
                STABLE: begin
                    if (!locked_s) begin
                        state_d  = WAIT_LOCK;
                        to_cnt_d = '0;
                    end else if (stb_cnt_q == SW'(LOCK_STABLE_CYCLES - 1)) begin
                        state_d = RUN;
                        retry_d = '0;
                    end else begin
                        stb_cnt_d = stb_cnt_q + SW'(1);
                    end
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d     = PLL_RESET;
                        lock_lost_d = 1'b1;
                    end
                end
                FAULT:   state_d = FAULT;
                default: state_d = PLL_RESET;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= PLL_RESET;
            rst_cnt_q   <= '0;
            stb_cnt_q   <= '0;
            to_cnt_q    <= '0;
            retry_q     <= '0;
            pll_rst     <= 1'b1;
            sys_reset_n <= 1'b0;
            ready       <= 1'b0;
            fault       <= 1'b0;
            lock_lost   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rst_cnt_q   <= rst_cnt_d;
            stb_cnt_q   <= stb_cnt_d;
            to_cnt_q    <= to_cnt_d;
            retry_q     <= retry_d;
            pll_rst     <= (state_d == PLL_RESET) || (state_d == FAULT);
            sys_reset_n <= (state_d == RUN);
            ready       <= (state_d == RUN);
            fault       <= (state_d == FAULT);
            lock_lost   <= lock_lost_d;
        end
    end

    assign retry_count = retry_q;
endmodule

// File: doc/pll_lock_reset_sequencer.md
Name: pll_lock_reset_sequencer

Overview:
Companion to the system PLL wrapper. It drives the PLL `rst` input and consumes the PLL `locked` output. It produces a clean, lock-qualified, active-low system reset for downstream logic. Runs on the free-running PLL reference clock, so it is independent of PLL output validity. Handles power-up sequencing, lock timeouts with bounded retries, and loss-of-lock recovery.

Parameters:
PLL_RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
LOCK_STABLE_CYCLES, 1024, consecutive cycles locked must stay high before release (>=1)
LOCK_TIMEOUT_CYCLES, 65536, max cycles in WAIT_LOCK before a retry (>=2)
MAX_RETRIES, 7, reset attempts after the first before FAULT (1..15)
SYNC_STAGES, 2, flops in the locked synchroniser (>=2)

Ports:
clk  input  1  reference clock (same net as the PLL refclk)
reset_n  input  1  asynchronous active-low reset
locked  input  1  PLL lock indicator; asynchronous to clk
soft_reset_req  input  1  single-cycle request to restart the full sequence
pll_rst  output  1  active-high reset to the PLL
sys_reset_n  output  1  active-low system reset; deasserts only in RUN
ready  output  1  high in RUN
fault  output  1  high in FAULT (retries exhausted)
retry_count  output  4  reset attempts made in the current sequence
lock_lost  output  1  one-cycle pulse when lock drops while in RUN

Behaviour:
- All outputs are registered.
- Reset values: pll_rst=1, sys_reset_n=0, ready=0, fault=0, retry_count=0, lock_lost=0. State=PLL_RESET, all counters 0.
- locked passes through SYNC_STAGES flops to form locked_s; the synchroniser is reset to 0. Decisions use locked_s only, giving SYNC_STAGES cycles of latency.
- States: PLL_RESET, WAIT_LOCK, STABLE, RUN, FAULT.
- PLL_RESET:
  - pll_rst=1, sys_reset_n=0.
  - Counter runs 0..PLL_RST_CYCLES-1; the state is left after exactly PLL_RST_CYCLES cycles, going to WAIT_LOCK.
  - On leaving, the timeout counter clears.
- WAIT_LOCK:
  - pll_rst=0.
  - If locked_s=1, go to STABLE and clear the stable counter.
  - Else, when the timeout counter reaches LOCK_TIMEOUT_CYCLES-1:
    - retry_count==MAX_RETRIES goes to FAULT;
    - otherwise retry_count++ and go to PLL_RESET.
  - locked_s=1 wins over timeout in the same cycle.
- STABLE:
  - pll_rst=0.
  - If locked_s=0, return to WAIT_LOCK with the timeout counter cleared. retry_count is unchanged; lock glitches do not consume retries.
  - When the stable counter reaches LOCK_STABLE_CYCLES-1 with locked_s=1, go to RUN.
- RUN:
  - sys_reset_n=1, ready=1, retry_count cleared on entry.
  - If locked_s=0: lock_lost=1 for exactly one cycle; next state PLL_RESET.
  - sys_reset_n and ready fall on the same edge that lock_lost rises.
  - Loss-of-lock recovery starts with retry_count=0.
- FAULT:
  - pll_rst=1, sys_reset_n=0, ready=0, fault=1.
  - Held until soft_reset_req or reset_n.
- soft_reset_req=1 in any state has highest priority:
  - next state PLL_RESET; all counters and retry_count clear; fault clears.
  - If issued in RUN, lock_lost is not pulsed.
- reset_n assertion mid-operation asynchronously forces the reset values; the sequence restarts on deassertion.
- Counter widths are $clog2 of each parameter, with no wrap beyond terminal counts. Counters hold at terminal count only in states that do not exit on it.
- sys_reset_n never deasserts without locked_s having been 1 for LOCK_STABLE_CYCLES consecutive cycles.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum type pll_seq_state_t (5 encodings);
  - default parameter constants;
  - a function computing counter widths.
- One sub-module is natural: sync_bit, a generic SYNC_STAGES flop synchroniser with async active-low reset and a reset value parameter. It is reused for locked.

Test Plan (bench params: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2, SYNC_STAGES=2):
1. Release reset_n with locked rising 10 cycles later and held -> pll_rst high exactly 4 cycles; sys_reset_n/ready rise exactly 2+8 cycles after locked rises; retry_count=0.
2. locked held 0 -> pll_rst pulses 3 times (4 cycles each, 32 cycles apart in WAIT_LOCK); retry_count steps 1,2; then fault=1, pll_rst=1, sys_reset_n=0 stay indefinitely.
3. In RUN, drop locked -> lock_lost pulses one cycle 2 cycles later; sys_reset_n=0 same edge; pll_rst high 4 cycles; locked restored gives RUN again with retry_count=0.
4. In STABLE, glitch locked low for 3 cycles after 5 stable cycles -> returns to WAIT_LOCK; ready rises only 8 cycles after locked_s re-rises; retry_count unchanged.
5. In FAULT, pulse soft_reset_req -> next cycle state PLL_RESET, fault=0, retry_count=0; normal lock gives ready=1.
6. Assert reset_n mid-STABLE and mid-RUN -> outputs immediately at reset values (pll_rst=1, sys_reset_n=0) with no clock edge required.
